// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Single-outstanding instruction fetch controller with redirect and stale-response drop.
// Optional misaligned-redirect fault reporting is enabled by FETCH_MISALIGN_CHECK_EN.
module ifu_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_drop, w_drop_nxt;
  logic            r_inst_valid, w_inst_valid_nxt;
  logic [ILEN-1:0] r_inst, w_inst_nxt;
  logic [XLEN-1:0] r_inst_pc, w_inst_pc_nxt;

  logic            w_misalign;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_req_fire;
  logic            w_go_fault;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_misalign  = pc_misaligned(redirect_pc);
  assign w_redir_pc  = redirect_pc;
  assign fetch_fault = r_inst_valid & (r_state == S_FAULT);
`else
  logic w_unused_pc_lsb;
  assign w_misalign      = 1'b0;
  assign w_redir_pc      = {redirect_pc[XLEN-1:2], 2'b00};
  assign fetch_fault     = 1'b0;
  assign w_unused_pc_lsb = ^redirect_pc[1:0];
`endif

  // Request is suppressed while reset is held even though the state reads S_REQ.
  assign imem_req_valid = rst_n & (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;

  assign w_req_fire = imem_req_valid & imem_req_ready;
  assign w_go_fault = redirect_valid & w_misalign;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drop_nxt       = r_drop;
    w_inst_valid_nxt = r_inst_valid;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;

    unique case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_nxt   = w_redir_pc;
          // A request accepted alongside a redirect fetched the old address.
          w_drop_nxt = w_req_fire;
          if (w_req_fire) w_state_nxt = S_WAIT;
        end else if (w_req_fire) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt   = w_redir_pc;
          w_drop_nxt = ~imem_rsp_valid;
          if (imem_rsp_valid) w_state_nxt = S_REQ;
        end else if (imem_rsp_valid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_inst_nxt       = imem_rsp_data;
            w_inst_pc_nxt    = r_pc;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt         = w_redir_pc;
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
        end else if (inst_ready) begin
          w_pc_nxt         = r_pc + 64'd4;
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
        end
      end
      S_FAULT: begin
        // Drop here tracks a stale response still in flight from before the fault.
        w_drop_nxt = r_drop & ~imem_rsp_valid;
        if (redirect_valid) begin
          w_pc_nxt         = w_redir_pc;
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = w_drop_nxt ? S_WAIT : S_REQ;
        end else if (inst_ready) begin
          w_inst_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase

    if (w_go_fault) begin
      w_state_nxt      = S_FAULT;
      w_inst_valid_nxt = 1'b1;
      w_inst_nxt       = '0;
      w_inst_pc_nxt    = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
    end
  end

endmodule
